// File: rtl/tdm_demux_if.sv
// Serial TDM link bundle: serial bit/valid/marker in, parallel lanes and status out.
// Latency: n/a (signal container only).
// Backpressure: none; the serial side is push-only and the receiver always accepts.
interface tdm_demux_if #(
    parameter int LANES = 4
);
    logic             din;
    logic             din_valid;
    logic             frame;
    logic [LANES-1:0] dout;
    logic [LANES-1:0] lane_strobe;
    logic             frame_done;
    logic             sync_err;
    logic             locked;

    // Serial source side: drives the wire, observes the demux results
    modport master (
        output din, din_valid, frame,
        input  dout, lane_strobe, frame_done, sync_err, locked
    );

    // Demux side: consumes the wire, produces lanes and status
    modport slave (
        input  din, din_valid, frame,
        output dout, lane_strobe, frame_done, sync_err, locked
    );
endinterface

// File: rtl/tdm_demux.sv
// Bit-serial TDM receiver: hunts for the frame marker, then steers each valid bit into its lane register.
// Latency: 1 clk from the input cycle to every output (all outputs registered).
// Backpressure: none; din_valid=0 cycles simply hold slot, state and lanes.
module tdm_demux #(
    parameter int LANES  = 4,
    parameter int SLOT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    tdm_demux_if.slave  link
);
    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(LANES - 1);

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [LANES-1:0]  dout_q, dout_d;
    logic [LANES-1:0]  strobe_q, strobe_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              slot_ok;
    logic [LANES-1:0]  slot_onehot;

    // Decode the current slot into a lane mask; slot values beyond the last lane decode to nothing
    always_comb begin
        slot_ok     = 1'b0;
        slot_onehot = '0;
        for (int i = 0; i < LANES; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                slot_ok        = 1'b1;
                slot_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state: marker hunting, lane steering, resync on early marker, drop lock on missing marker
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        dout_d   = dout_q;
        strobe_d = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (link.din_valid) begin
            case (state_q)
                HUNT: begin
                    // Bits before the first marker carry no slot position and are discarded
                    if (link.frame) begin
                        dout_d[0]   = link.din;
                        strobe_d[0] = 1'b1;
                        slot_d      = SLOT_ONE;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (!slot_ok) begin
                        // Corrupt slot counter: treat like a lost marker and re-hunt
                        err_d   = 1'b1;
                        slot_d  = '0;
                        state_d = HUNT;
                    end else if (link.frame) begin
                        // Marker always restarts at lane 0; off-boundary markers flag an error
                        err_d       = (slot_q != '0);
                        dout_d[0]   = link.din;
                        strobe_d[0] = 1'b1;
                        slot_d      = SLOT_ONE;
                    end else if (slot_q == '0) begin
                        // Frame boundary reached without a marker: lock is lost
                        err_d   = 1'b1;
                        slot_d  = '0;
                        state_d = HUNT;
                    end else begin
                        dout_d   = (dout_q & ~slot_onehot) | (link.din ? slot_onehot : '0);
                        strobe_d = slot_onehot;
                        if (slot_q == SLOT_LAST) begin
                            slot_d = '0;
                            done_d = 1'b1;
                        end else begin
                            slot_d = slot_q + SLOT_ONE;
                        end
                    end
                end
                default: begin
                    slot_d  = '0;
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            slot_q   <= '0;
            dout_q   <= '0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            dout_q   <= dout_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign link.dout        = dout_q;
    assign link.lane_strobe = strobe_q;
    assign link.frame_done  = done_q;
    assign link.sync_err    = err_q;
    assign link.locked      = (state_q == RUN);
endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux with LANES=4: directed serial frames, expectations queued at drive time.
// Latency: outputs compared 1 ns after the edge that samples each input cycle.
// Backpressure: none exercised beyond din_valid idle cycles.
module tb_tdm_demux;
    localparam int LANES  = 4;
    localparam int SLOT_W = 2;

    typedef struct packed {
        logic [LANES-1:0] dout;
        logic [LANES-1:0] strobe;
        logic             done;
        logic             err;
        logic             locked;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    tdm_demux_if #(.LANES(LANES)) link ();

    tdm_demux #(.LANES(LANES), .SLOT_W(SLOT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, expv);
        end
    endtask

    // Drive one input cycle, queue its expected outcome, then compare after the sampling edge
    task automatic step(input logic d, input logic v, input logic f,
                        input logic [LANES-1:0] e_dout, input logic [LANES-1:0] e_stb,
                        input logic e_done, input logic e_err, input logic e_lock);
        exp_t e;
        link.din       = d;
        link.din_valid = v;
        link.frame     = f;
        exp_q.push_back('{dout: e_dout, strobe: e_stb, done: e_done, err: e_err, locked: e_lock});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("dout",        32'(link.dout),        32'(e.dout));
            check("lane_strobe", 32'(link.lane_strobe), 32'(e.strobe));
            check("frame_done",  32'(link.frame_done),  32'(e.done));
            check("sync_err",    32'(link.sync_err),    32'(e.err));
            check("locked",      32'(link.locked),      32'(e.locked));
        end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        link.din       = 1'b0;
        link.din_valid = 1'b0;
        link.frame     = 1'b0;

        // Reset state
        #12;
        check("rst_dout",   32'(link.dout),        32'd0);
        check("rst_strobe", 32'(link.lane_strobe), 32'd0);
        check("rst_done",   32'(link.frame_done),  32'd0);
        check("rst_err",    32'(link.sync_err),    32'd0);
        check("rst_locked", 32'(link.locked),      32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Hunt: unmarked bits and idle markers are ignored
        step(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
        step(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
        step(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
        step(1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
        step(1, 1, 1, 4'b0001, 4'b0001, 0, 0, 1);
        step(0, 1, 0, 4'b0001, 4'b0010, 0, 0, 1);
        step(0, 1, 0, 4'b0001, 4'b0100, 0, 0, 1);
        step(0, 1, 0, 4'b0001, 4'b1000, 1, 0, 1);

        // Full frame 1,0,1,1 back to back
        step(1, 1, 1, 4'b0001, 4'b0001, 0, 0, 1);
        step(0, 1, 0, 4'b0001, 4'b0010, 0, 0, 1);
        step(1, 1, 0, 4'b0101, 4'b0100, 0, 0, 1);
        step(1, 1, 0, 4'b1101, 4'b1000, 1, 0, 1);

        // Frame 0,1,0,0 so the stalled frame below changes every lane it can
        step(0, 1, 1, 4'b1100, 4'b0001, 0, 0, 1);
        step(1, 1, 0, 4'b1110, 4'b0010, 0, 0, 1);
        step(0, 1, 0, 4'b1010, 4'b0100, 0, 0, 1);
        step(0, 1, 0, 4'b0010, 4'b1000, 1, 0, 1);

        // Stalled frame 1,0,1,1 with two idles (frame held high) between bits
        step(1, 1, 1, 4'b0011, 4'b0001, 0, 0, 1);
        step(1, 0, 1, 4'b0011, 4'b0000, 0, 0, 1);
        step(0, 0, 1, 4'b0011, 4'b0000, 0, 0, 1);
        step(0, 1, 0, 4'b0001, 4'b0010, 0, 0, 1);
        step(0, 0, 1, 4'b0001, 4'b0000, 0, 0, 1);
        step(1, 0, 1, 4'b0001, 4'b0000, 0, 0, 1);
        step(1, 1, 0, 4'b0101, 4'b0100, 0, 0, 1);
        step(0, 0, 1, 4'b0101, 4'b0000, 0, 0, 1);
        step(0, 0, 1, 4'b0101, 4'b0000, 0, 0, 1);
        step(1, 1, 0, 4'b1101, 4'b1000, 1, 0, 1);

        // Early marker on slot 2: resync to lane 0, no frame_done, next bit lands in lane 1
        step(1, 1, 1, 4'b1101, 4'b0001, 0, 0, 1);
        step(1, 1, 0, 4'b1111, 4'b0010, 0, 0, 1);
        step(0, 1, 1, 4'b1110, 4'b0001, 0, 1, 1);
        step(0, 1, 0, 4'b1100, 4'b0010, 0, 0, 1);
        step(0, 1, 0, 4'b1000, 4'b0100, 0, 0, 1);
        step(0, 1, 0, 4'b0000, 4'b1000, 1, 0, 1);

        // Missing marker after a complete frame: drop lock, then relock on the next marker
        step(1, 1, 0, 4'b0000, 4'b0000, 0, 1, 0);
        step(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
        step(1, 1, 1, 4'b0001, 4'b0001, 0, 0, 1);

        // Build dout=1011 and stop mid-frame just after a lane-0 write
        step(1, 1, 0, 4'b0011, 4'b0010, 0, 0, 1);
        step(0, 1, 0, 4'b0011, 4'b0100, 0, 0, 1);
        step(1, 1, 0, 4'b1011, 4'b1000, 1, 0, 1);
        step(1, 1, 1, 4'b1011, 4'b0001, 0, 0, 1);

        // Asynchronous reset between edges clears everything before the next edge
        #2;
        link.din_valid = 1'b0;
        link.frame     = 1'b0;
        rst            = 1'b1;
        #1;
        check("arst_dout",   32'(link.dout),        32'd0);
        check("arst_strobe", 32'(link.lane_strobe), 32'd0);
        check("arst_locked", 32'(link.locked),      32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // After reset a marker is required again
        step(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
        step(1, 1, 1, 4'b0001, 4'b0001, 0, 0, 1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
